dmem_ls_arbiter: RTL and testbench

- Per-cycle arbiter and sequencer for the single DMEM port shared by the scalar unit (SU) load/store path and the DMA engine (RDRAM<->DMEM word bursts).
- Grants one access per cycle and drives registered DMEM controls in DF.
- Produces the EX/WB control sideband for the load/store datapath: rotation, size flags, sign handling and ls bus drive, with timing aligned to the datapath's EX->DF->WB pipeline.

---
 rtl/ls_pkg.sv | 34 +++
 rtl/ls_ctrl_pipe.sv | 67 ++++++
 rtl/dmem_ls_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_ls_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared types and helpers for the DMEM load/store arbiter: access sizes,
// DMA sequencer states, byte-enable generation and alignment checking.
package ls_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } ls_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } dma_state_e;

  // Size code 2'b11 falls through to the word case everywhere.
  function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] be;
    if (size == BYTE)      be = 4'b0001 << addr;
    else if (size == HALF) be = addr[1] ? 4'b1100 : 4'b0011;
    else                   be = 4'b1111;
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic mis;
    if (size == BYTE)      mis = 1'b0;
    else if (size == HALF) mis = addr[0];
    else                   mis = (addr != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/ls_ctrl_pipe.sv
// Two-stage EX->DF->WB register chain carrying DMEM controls (consumed in DF)
// and the load/DMA sideband (consumed in WB).
module ls_ctrl_pipe #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_en,
  input  logic          ex_we,
  input  logic [3:0]    ex_be,
  input  logic [AW-1:0] ex_addr,
  input  logic          ex_su_load,
  input  logic          ex_uns,
  input  logic [1:0]    ex_rot,
  input  logic          ex_dma_rd,
  output logic          df_en,
  output logic          df_we,
  output logic [3:0]    df_be,
  output logic [AW-1:0] df_addr,
  output logic          wb_su_load,
  output logic          wb_uns,
  output logic [1:0]    wb_rot,
  output logic          wb_dma_rd
);

  logic       df_su_load;
  logic       df_uns;
  logic [1:0] df_rot;
  logic       df_dma_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      df_en      <= 1'b0;
      df_we      <= 1'b0;
      df_be      <= 4'b0000;
      df_addr    <= '0;
      df_su_load <= 1'b0;
      df_uns     <= 1'b0;
      df_rot     <= 2'b00;
      df_dma_rd  <= 1'b0;
    end else begin
      df_en      <= ex_en;
      df_we      <= ex_we;
      df_be      <= ex_be;
      df_addr    <= ex_addr;
      df_su_load <= ex_su_load;
      df_uns     <= ex_uns;
      df_rot     <= ex_rot;
      df_dma_rd  <= ex_dma_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_su_load <= 1'b0;
      wb_uns     <= 1'b0;
      wb_rot     <= 2'b00;
      wb_dma_rd  <= 1'b0;
    end else begin
      wb_su_load <= df_su_load;
      wb_uns     <= df_uns;
      wb_rot     <= df_rot;
      wb_dma_rd  <= df_dma_rd;
    end
  end

endmodule

// File: rtl/dmem_ls_arbiter.sv
// Single-port DMEM arbiter between the scalar-unit load/store path and the
// DMA burst engine, with a starvation guard so DMA always makes progress.
module dmem_ls_arbiter
  import ls_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int LEN_W      = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              su_valid,
  input  logic              su_load,
  input  logic [1:0]        su_size,
  input  logic              su_uns,
  input  logic [ADDR_W-1:0] su_addr,
  output logic              su_stall,
  output logic              su_misalign,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  output logic              dma_busy,
  output logic              dma_beat,
  output logic              dma_rd_valid,
  output logic              dma_done,
  output logic              dmem_en,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-3:0] dmem_addr,
  output logic [1:0]        ex_rot,
  output logic              ex_su_byte_ls,
  output logic              ex_su_half_ls,
  output logic [1:0]        wb_rot,
  output logic              wb_su_load,
  output logic              wb_su_uns_ls,
  output logic              ls_drive_ls
);

  localparam int WA_W = ADDR_W - 2;
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  dma_state_e       state, state_next;
  logic [WA_W-1:0]  beat_addr;
  logic [LEN_W-1:0] count;
  logic             burst_wr;
  logic [SC_W-1:0]  starve_cnt;

  logic            misalign, su_ok, in_burst, starved;
  logic            dma_grant, su_grant, su_sub;
  logic            ex_en, ex_we, ex_su_load, ex_uns, ex_dma_rd;
  logic [3:0]      ex_be;
  logic [WA_W-1:0] ex_addr;
  logic [1:0]      ex_ls_rot;
  logic            wb_dma_rd, wb_uns;
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^dma_addr[1:0];

  // DMA takes the slot in BURST whenever the SU cannot use it, or when starved.
  assign misalign  = su_valid && is_misaligned(su_size, su_addr[1:0]);
  assign su_ok     = su_valid && !misalign;
  assign in_burst  = (state == BURST);
  assign starved   = (starve_cnt == SC_W'(STARVE_MAX));
  assign dma_grant = in_burst && (!su_ok || starved);
  assign su_grant  = su_ok && !dma_grant;
  assign su_sub    = (su_size == BYTE) || (su_size == HALF);

  assign su_stall      = su_ok && dma_grant;
  assign su_misalign   = misalign;
  assign dma_beat      = dma_grant;
  assign dma_busy      = (state != IDLE);
  assign dma_done      = (state == DONE);
  assign ex_rot        = (su_grant && su_sub) ? su_addr[1:0] : 2'b00;
  assign ex_su_byte_ls = su_grant && (su_size == BYTE);
  assign ex_su_half_ls = su_grant && (su_size == HALF);

  always_comb begin
    ex_en      = su_grant || dma_grant;
    ex_we      = 1'b0;
    ex_be      = 4'b0000;
    ex_addr    = '0;
    ex_su_load = 1'b0;
    ex_uns     = 1'b0;
    ex_ls_rot  = 2'b00;
    ex_dma_rd  = 1'b0;
    if (su_grant) begin
      ex_we      = !su_load;
      ex_be      = su_load ? 4'b0000 : be_from_size(su_size, su_addr[1:0]);
      ex_addr    = su_addr[ADDR_W-1:2];
      ex_su_load = su_load;
      ex_uns     = su_load && su_uns;
      ex_ls_rot  = su_load ? su_addr[1:0] : 2'b00;
    end else if (dma_grant) begin
      ex_we     = burst_wr;
      ex_be     = burst_wr ? 4'b1111 : 4'b0000;
      ex_addr   = beat_addr;
      ex_dma_rd = !burst_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dma_req) state_next = BURST;
      BURST:   if (dma_grant && count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst address wraps naturally at the DMEM size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_addr <= '0;
      count     <= '0;
      burst_wr  <= 1'b0;
    end else if (state == IDLE && dma_req) begin
      beat_addr <= dma_addr[ADDR_W-1:2];
      count     <= dma_len;
      burst_wr  <= dma_wr;
    end else if (dma_grant) begin
      beat_addr <= beat_addr + 1'b1;
      count     <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 starve_cnt <= '0;
    else if (dma_grant)                      starve_cnt <= '0;
    else if (in_burst && su_grant && !starved) starve_cnt <= starve_cnt + 1'b1;
  end

  ls_ctrl_pipe #(.AW(WA_W)) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .ex_en      (ex_en),
    .ex_we      (ex_we),
    .ex_be      (ex_be),
    .ex_addr    (ex_addr),
    .ex_su_load (ex_su_load),
    .ex_uns     (ex_uns),
    .ex_rot     (ex_ls_rot),
    .ex_dma_rd  (ex_dma_rd),
    .df_en      (dmem_en),
    .df_we      (dmem_we),
    .df_be      (dmem_be),
    .df_addr    (dmem_addr),
    .wb_su_load (wb_su_load),
    .wb_uns     (wb_uns),
    .wb_rot     (wb_rot),
    .wb_dma_rd  (wb_dma_rd)
  );

  assign dma_rd_valid = wb_dma_rd;
  assign wb_su_uns_ls = wb_uns;
  assign ls_drive_ls  = wb_su_load;

endmodule

// File: tb/tb_dmem_ls_arbiter.sv
// Self-checking bench for dmem_ls_arbiter: directed scenarios then random
// traffic, all compared against a transaction-level model of the arbiter.
module tb_dmem_ls_arbiter;

  localparam int ADDR_W     = 12;
  localparam int LEN_W      = 8;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              su_valid, su_load, su_uns;
  logic [1:0]        su_size;
  logic [ADDR_W-1:0] su_addr;
  logic              su_stall, su_misalign;
  logic              dma_req, dma_wr;
  logic [ADDR_W-1:0] dma_addr;
  logic [LEN_W-1:0]  dma_len;
  logic              dma_busy, dma_beat, dma_rd_valid, dma_done;
  logic              dmem_en, dmem_we;
  logic [3:0]        dmem_be;
  logic [ADDR_W-3:0] dmem_addr;
  logic [1:0]        ex_rot, wb_rot;
  logic              ex_su_byte_ls, ex_su_half_ls;
  logic              wb_su_load, wb_su_uns_ls, ls_drive_ls;

  always #5 clk = ~clk;

  dmem_ls_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .su_valid(su_valid), .su_load(su_load), .su_size(su_size), .su_uns(su_uns),
    .su_addr(su_addr), .su_stall(su_stall), .su_misalign(su_misalign),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_beat(dma_beat), .dma_rd_valid(dma_rd_valid),
    .dma_done(dma_done), .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .ex_rot(ex_rot), .ex_su_byte_ls(ex_su_byte_ls),
    .ex_su_half_ls(ex_su_half_ls), .wb_rot(wb_rot), .wb_su_load(wb_su_load),
    .wb_su_uns_ls(wb_su_uns_ls), .ls_drive_ls(ls_drive_ls)
  );

  typedef struct packed {
    logic       en;
    logic       we;
    logic [3:0] be;
    logic [9:0] addr;
    logic       su_load;
    logic       uns;
    logic [1:0] rot;
    logic       dma_rd;
  } acc_t;

  // Model state: pending accesses in DF/WB and the burst described as counts.
  acc_t exp_df, exp_wb;
  int   burst_left;
  bit   done_pending;
  int   burst_word;
  bit   burst_wr;
  int   starve;
  bit   last_stall;
  int   beats_seen, stalls_seen;
  int   checks, failures;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    exp_df = '0;
    exp_wb = '0;
    burst_left = 0;
    done_pending = 0;
    burst_word = 0;
    burst_wr = 0;
    starve = 0;
    last_stall = 0;
  endtask

  // Drives one cycle of inputs, checks every output mid-cycle, then advances the model.
  task automatic applyStimulus(input bit v, input bit ld, input logic [1:0] sz, input bit uns,
                               input logic [11:0] a, input bit req, input bit wr,
                               input logic [11:0] da, input logic [7:0] dl);
    bit   misal, in_burst, su_ok, dma_gets, su_gets;
    int   lo, nbytes, mask;
    acc_t nxt;
    su_valid = v; su_load = ld; su_size = sz; su_uns = uns; su_addr = a;
    dma_req = req; dma_wr = wr; dma_addr = da; dma_len = dl;
    #1;
    lo       = int'(a[1:0]);
    nbytes   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    misal    = v && ((lo % nbytes) != 0);
    in_burst = burst_left > 0;
    su_ok    = v && !misal;
    dma_gets = in_burst && (!su_ok || starve >= STARVE_MAX);
    su_gets  = su_ok && !dma_gets;
    if (dma_beat === 1'b1) beats_seen++;
    if (su_stall === 1'b1) stalls_seen++;

    checkOutput("su_stall", su_stall, su_ok && dma_gets);
    checkOutput("su_misalign", su_misalign, misal);
    checkOutput("dma_beat", dma_beat, dma_gets);
    checkOutput("dma_busy", dma_busy, in_burst || done_pending);
    checkOutput("dma_done", dma_done, done_pending);
    checkOutput("ex_rot", ex_rot, (su_gets && nbytes < 4) ? lo : 0);
    checkOutput("ex_byte", ex_su_byte_ls, su_gets && sz == 2'd0);
    checkOutput("ex_half", ex_su_half_ls, su_gets && sz == 2'd1);
    checkOutput("dmem_en", dmem_en, exp_df.en);
    checkOutput("dmem_we", dmem_we, exp_df.we);
    checkOutput("dmem_be", dmem_be, exp_df.be);
    checkOutput("dmem_addr", dmem_addr, exp_df.addr);
    checkOutput("wb_su_load", wb_su_load, exp_wb.su_load);
    checkOutput("wb_uns", wb_su_uns_ls, exp_wb.uns);
    checkOutput("wb_rot", wb_rot, exp_wb.rot);
    checkOutput("ls_drive", ls_drive_ls, exp_wb.su_load);
    checkOutput("dma_rd_valid", dma_rd_valid, exp_wb.dma_rd);

    nxt = '0;
    if (su_gets) begin
      mask        = ((1 << nbytes) - 1) << lo;
      nxt.en      = 1'b1;
      nxt.we      = !ld;
      nxt.addr    = a[11:2];
      nxt.be      = ld ? 4'b0000 : mask[3:0];
      nxt.su_load = ld;
      nxt.uns     = ld && uns;
      nxt.rot     = ld ? a[1:0] : 2'b00;
    end else if (dma_gets) begin
      nxt.en     = 1'b1;
      nxt.we     = burst_wr;
      nxt.be     = burst_wr ? 4'b1111 : 4'b0000;
      nxt.addr   = burst_word[9:0];
      nxt.dma_rd = !burst_wr;
    end
    last_stall = su_ok && dma_gets;

    @(posedge clk);
    exp_wb = exp_df;
    exp_df = nxt;
    if (dma_gets) begin
      burst_word = (burst_word + 1) % 1024;
      burst_left--;
      if (burst_left == 0) done_pending = 1;
      starve = 0;
    end else begin
      if (done_pending) done_pending = 0;
      else if (!in_burst && req) begin
        burst_left = int'(dl) + 1;
        burst_word = int'(da) / 4;
        burst_wr   = wr;
      end
      if (in_burst && su_gets && starve < STARVE_MAX) starve++;
    end
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 2'd0, 0, 12'h000, 0, 0, 12'h000, 8'd0);
  endtask

  task automatic doReset();
    su_valid = 0; su_load = 0; su_size = 0; su_uns = 0; su_addr = '0;
    dma_req = 0; dma_wr = 0; dma_addr = '0; dma_len = '0;
    rst = 1'b1;
    #1;
    checkOutput("rst_dmem", {dmem_en, dmem_we, dmem_be, dmem_addr}, 0);
    checkOutput("rst_wb", {wb_su_load, wb_su_uns_ls, wb_rot, ls_drive_ls}, 0);
    checkOutput("rst_dma", {dma_busy, dma_beat, dma_rd_valid, dma_done}, 0);
    checkOutput("rst_ex", {ex_rot, ex_su_byte_ls, ex_su_half_ls, su_stall, su_misalign}, 0);
    modelClear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit              r_v, r_ld, r_uns;
    logic [1:0]      r_sz;
    logic [11:0]     r_a;
    checks = 0;
    failures = 0;
    beats_seen = 0;
    stalls_seen = 0;
    doReset();

    $display("[TB] byte store 0x013");
    applyStimulus(1, 0, 2'd0, 0, 12'h013, 0, 0, 12'h000, 8'd0);
    checkOutput("t1_en", dmem_en, 1);
    checkOutput("t1_we", dmem_we, 1);
    checkOutput("t1_be", dmem_be, 4'b1000);
    checkOutput("t1_addr", dmem_addr, 10'h004);

    $display("[TB] signed half load 0x022");
    applyStimulus(1, 1, 2'd1, 0, 12'h022, 0, 0, 12'h000, 8'd0);
    idleCycle();
    checkOutput("t2_wb_load", wb_su_load, 1);
    checkOutput("t2_wb_rot", wb_rot, 2);
    checkOutput("t2_wb_uns", wb_su_uns_ls, 0);
    checkOutput("t2_drive", ls_drive_ls, 1);

    $display("[TB] DMA read burst 0x100 len 3");
    beats_seen = 0;
    applyStimulus(0, 0, 2'd0, 0, 12'h000, 1, 0, 12'h100, 8'd3);
    for (int i = 0; i < 7; i++) idleCycle();
    checkOutput("t3_beats", beats_seen, 4);
    checkOutput("t3_busy", dma_busy, 0);

    $display("[TB] starvation pattern");
    beats_seen = 0;
    stalls_seen = 0;
    applyStimulus(0, 0, 2'd0, 0, 12'h000, 1, 1, 12'h300, 8'd3);
    for (int i = 0; i < 22; i++) applyStimulus(1, 1, 2'd2, 0, 12'h040, 0, 0, 12'h000, 8'd0);
    checkOutput("t4_beats", beats_seen, 4);
    checkOutput("t4_stalls", stalls_seen, 4);
    idleCycle();

    $display("[TB] misaligned word load");
    applyStimulus(1, 1, 2'd2, 0, 12'h006, 0, 0, 12'h000, 8'd0);
    checkOutput("t5_idle_en", dmem_en, 0);
    applyStimulus(0, 0, 2'd0, 0, 12'h000, 1, 0, 12'h080, 8'd1);
    applyStimulus(1, 1, 2'd2, 0, 12'h006, 0, 0, 12'h000, 8'd0);
    checkOutput("t5_dma_en", dmem_en, 1);
    checkOutput("t5_dma_addr", dmem_addr, 10'h020);
    for (int i = 0; i < 4; i++) idleCycle();

    $display("[TB] reset mid-burst");
    applyStimulus(0, 0, 2'd0, 0, 12'h000, 1, 1, 12'h200, 8'd7);
    idleCycle();
    idleCycle();
    doReset();
    applyStimulus(0, 0, 2'd0, 0, 12'h000, 1, 0, 12'h044, 8'd1);
    idleCycle();
    checkOutput("t6_addr", dmem_addr, 10'h011);
    for (int i = 0; i < 4; i++) idleCycle();

    $display("[TB] random traffic");
    r_v = 0; r_ld = 0; r_uns = 0; r_sz = 0; r_a = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        r_v   = ($urandom_range(0, 3) != 0);
        r_ld  = $urandom_range(0, 1) != 0;
        r_uns = $urandom_range(0, 1) != 0;
        r_sz  = 2'($urandom_range(0, 3));
        r_a   = 12'($urandom);
      end
      applyStimulus(r_v, r_ld, r_sz, r_uns, r_a, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) != 0, 12'($urandom), 8'($urandom_range(0, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
